// File: rtl/mse_pkg.sv
// Shared constants, frame layout and FSM state type for the MSE serial slave.
package mse_pkg;

  localparam int unsigned DEF_ADDR_W = 7;
  localparam int unsigned DEF_DATA_W = 8;

  // Frame layout with default widths: R/W, address, turnaround, data (MSB first)
  localparam int unsigned FRAME_LEN = 2 + DEF_ADDR_W + DEF_DATA_W;
  localparam int unsigned ADDR_LAST = DEF_ADDR_W;
  localparam int unsigned TURN_BIT  = DEF_ADDR_W + 1;
  localparam int unsigned DATA_LAST = FRAME_LEN - 1;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    TURN,
    DATA,
    DONE
  } mse_state_e;

endpackage

// File: rtl/mse_serial_slave_if.sv
// Serial link signals between the MSE host and the serial slave.
interface mse_serial_slave_if;

  logic mse_sdi;
  logic mse_sle;
  logic mse_sdo;
  logic mse_srdy;

  modport slave (
    input  mse_sdi,
    input  mse_sle,
    output mse_sdo,
    output mse_srdy
  );

  modport master (
    output mse_sdi,
    output mse_sle,
    input  mse_sdo,
    input  mse_srdy
  );

endinterface

// File: rtl/mse_shift_reg.sv
// Shared shifter: parallel load, serial shift-in at the LSB, MSB tap out.
module mse_shift_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         shift,
  input  logic         sin,
  output logic [W-1:0] q,
  output logic         msb
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = load_data;
    end else if (shift) begin
      q_d = W'({q_q, sin});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q   = q_q;
  assign msb = q_q[W-1];

endmodule

// File: rtl/mse_serial_slave.sv
// MSE serial front end: decodes framed serial transactions into single-cycle
// register read/write strobes and returns read data serially.
module mse_serial_slave
  import mse_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic                MSE_SCLK,
  input  logic                MSE_RESETN,
  mse_serial_slave_if.slave   link,
  output logic [ADDR_W-1:0]   reg_addr,
  output logic [DATA_W-1:0]   reg_wdata,
  output logic                reg_wr,
  output logic                reg_rd,
  input  logic [DATA_W-1:0]   reg_rdata,
  output logic [7:0]          err_cnt
);

  localparam int unsigned FLEN  = 2 + ADDR_W + DATA_W;
  localparam int unsigned CNT_W = $clog2(FLEN + 1);
  localparam logic [CNT_W-1:0] C_ADDR_LAST = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] C_DATA_LAST = CNT_W'(FLEN - 1);

  mse_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic              rd_q, rd_d;
  logic              sdo_q, sdo_d;
  logic              srdy_q, srdy_d;
  logic [7:0]        err_q, err_d;

  logic              sh_load;
  logic              sh_shift;
  logic [DATA_W-1:0] sh_load_data;
  logic [DATA_W-1:0] sh_q;
  logic              sh_msb;
  logic              abort;

  // The read word is loaded pre-shifted by one: its MSB goes straight to
  // mse_sdo at the load edge, so the shifter MSB then holds the next bit.
  assign sh_load_data = DATA_W'({reg_rdata, 1'b0});

  mse_shift_reg #(
    .W (DATA_W)
  ) u_shift (
    .clk       (MSE_SCLK),
    .rst_n     (MSE_RESETN),
    .load      (sh_load),
    .load_data (sh_load_data),
    .shift     (sh_shift),
    .sin       (link.mse_sdi),
    .q         (sh_q),
    .msb       (sh_msb)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rw_d     = rw_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    wr_d     = 1'b0;
    rd_d     = 1'b0;
    sdo_d    = 1'b0;
    sh_load  = 1'b0;
    sh_shift = 1'b0;
    abort    = 1'b0;

    case (state_q)
      IDLE: begin
        if (link.mse_sle) begin
          rw_d    = link.mse_sdi;
          cnt_d   = CNT_W'(1);
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (!link.mse_sle) begin
          abort = 1'b1;
        end else begin
          sh_shift = 1'b1;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == C_ADDR_LAST) begin
            addr_d  = ADDR_W'({sh_q, link.mse_sdi});
            rd_d    = (rw_q == RW_READ);
            state_d = TURN;
          end
        end
      end
      TURN: begin
        if (!link.mse_sle) begin
          abort = 1'b1;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = DATA;
          if (rw_q == RW_READ) begin
            sh_load = 1'b1;
            sdo_d   = reg_rdata[DATA_W-1];
          end
        end
      end
      DATA: begin
        if (!link.mse_sle) begin
          abort = 1'b1;
        end else begin
          sh_shift = 1'b1;
          cnt_d    = cnt_q + 1'b1;
          if (rw_q == RW_READ && cnt_q != C_DATA_LAST) begin
            sdo_d = sh_msb;
          end
          if (cnt_q == C_DATA_LAST) begin
            if (rw_q == RW_WRITE) begin
              wdata_d = DATA_W'({sh_q, link.mse_sdi});
              wr_d    = 1'b1;
            end
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (!link.mse_sle) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d = IDLE;
      if (err_q != '1) begin
        err_d = err_q + 1'b1;
      end
    end

    srdy_d = (state_d == IDLE);
  end

  always_ff @(posedge MSE_SCLK or negedge MSE_RESETN) begin
    if (!MSE_RESETN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      sdo_q   <= 1'b0;
      srdy_q  <= 1'b1;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      sdo_q   <= sdo_d;
      srdy_q  <= srdy_d;
      err_q   <= err_d;
    end
  end

  assign link.mse_sdo  = sdo_q;
  assign link.mse_srdy = srdy_q;
  assign reg_addr      = addr_q;
  assign reg_wdata     = wdata_q;
  assign reg_wr        = wr_q;
  assign reg_rd        = rd_q;
  assign err_cnt       = err_q;

endmodule

// File: tb/tb_mse_serial_slave.sv
// Self-checking bench for mse_serial_slave: directed frames plus randomized
// frames checked against a frame-level reference model of the register bank.
module tb_mse_serial_slave;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata;
  logic [7:0] err_cnt;
  logic       reg_wr;
  logic       reg_rd;

  mse_serial_slave_if link ();

  mse_serial_slave #(
    .ADDR_W (7),
    .DATA_W (8)
  ) dut (
    .MSE_SCLK   (clk),
    .MSE_RESETN (rst_n),
    .link       (link),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_wr     (reg_wr),
    .reg_rd     (reg_rd),
    .reg_rdata  (reg_rdata),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  // Register bank seen by the DUT, updated only from observed write strobes
  logic [7:0] dut_bank [128] = '{default: 8'h00};
  // Reference bank, updated from the frames the bench sends
  logic [7:0] ref_bank [128] = '{default: 8'h00};

  assign reg_rdata = dut_bank[reg_addr];

  int checks = 0;
  int failures = 0;
  int wr_cnt = 0;
  int exp_wr_cnt = 0;
  int exp_err = 0;

  always @(negedge clk) begin
    if (rst_n && reg_wr) begin
      dut_bank[reg_addr] = reg_wdata;
      wr_cnt = wr_cnt + 1;
    end
  end

  // One frame: abort_at in 1..16 drops mse_sle at that bit, -1 runs to the end;
  // extra = additional cycles spent in the trailer with mse_sle still high.
  task automatic send_frame(input bit rw, input bit [6:0] addr, input bit [7:0] data,
                            input int abort_at, input int extra);
    bit       fb [17];
    bit [7:0] exp_rd;
    logic     exp_sdo;
    fb[0] = rw;
    for (int i = 0; i < 7; i++) fb[1+i] = addr[6-i];
    fb[8] = 1'b0;
    for (int i = 0; i < 8; i++) fb[9+i] = data[7-i];
    exp_rd = ref_bank[addr];

    for (int k = 0; k < 17; k++) begin
      if (k == abort_at) begin
        link.mse_sle = 1'b0;
        link.mse_sdi = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        if (exp_err < 255) exp_err++;
        checks++;
        if (err_cnt !== 8'(exp_err)) begin
          failures++;
          $display("FAIL abort_err bit=%0d got=%0d exp=%0d", k, err_cnt, exp_err);
        end
        checks++;
        if (link.mse_srdy !== 1'b1 || reg_wr !== 1'b0 || link.mse_sdo !== 1'b0) begin
          failures++;
          $display("FAIL abort_outputs bit=%0d srdy=%b wr=%b sdo=%b exp 1,0,0",
                   k, link.mse_srdy, reg_wr, link.mse_sdo);
        end
        checks++;
        if (wr_cnt !== exp_wr_cnt) begin
          failures++;
          $display("FAIL abort_wr_count got=%0d exp=%0d", wr_cnt, exp_wr_cnt);
        end
        return;
      end
      link.mse_sle = 1'b1;
      link.mse_sdi = fb[k];
      @(posedge clk); #1;
      exp_sdo = (rw && k >= 8 && k <= 15) ? exp_rd[15-k] : 1'b0;
      checks++;
      if (link.mse_srdy !== 1'b0) begin
        failures++;
        $display("FAIL srdy_busy edge=%0d got=%b exp=0", k, link.mse_srdy);
      end
      checks++;
      if (reg_rd !== (rw && k == 7)) begin
        failures++;
        $display("FAIL reg_rd edge=%0d got=%b exp=%b", k, reg_rd, (rw && k == 7));
      end
      checks++;
      if (reg_wr !== (!rw && k == 16)) begin
        failures++;
        $display("FAIL reg_wr edge=%0d got=%b exp=%b", k, reg_wr, (!rw && k == 16));
      end
      checks++;
      if (link.mse_sdo !== exp_sdo) begin
        failures++;
        $display("FAIL sdo edge=%0d got=%b exp=%b", k, link.mse_sdo, exp_sdo);
      end
      if (k == 7) begin
        checks++;
        if (reg_addr !== addr) begin
          failures++;
          $display("FAIL reg_addr got=%h exp=%h", reg_addr, addr);
        end
      end
      if (k == 16 && !rw) begin
        checks++;
        if (reg_wdata !== data) begin
          failures++;
          $display("FAIL reg_wdata got=%h exp=%h", reg_wdata, data);
        end
      end
    end

    for (int e = 0; e < extra; e++) begin
      link.mse_sle = 1'b1;
      link.mse_sdi = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      checks++;
      if (link.mse_srdy !== 1'b0 || reg_wr !== 1'b0) begin
        failures++;
        $display("FAIL done_wait srdy=%b wr=%b exp 0,0", link.mse_srdy, reg_wr);
      end
    end

    link.mse_sle = 1'b0;
    link.mse_sdi = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    if (!rw) begin
      ref_bank[addr] = data;
      exp_wr_cnt++;
    end
    checks++;
    if (link.mse_srdy !== 1'b1 || reg_wr !== 1'b0) begin
      failures++;
      $display("FAIL frame_end srdy=%b wr=%b exp 1,0", link.mse_srdy, reg_wr);
    end
    checks++;
    if (err_cnt !== 8'(exp_err)) begin
      failures++;
      $display("FAIL frame_end_err got=%0d exp=%0d", err_cnt, exp_err);
    end
    checks++;
    if (wr_cnt !== exp_wr_cnt) begin
      failures++;
      $display("FAIL wr_count got=%0d exp=%0d", wr_cnt, exp_wr_cnt);
    end
  endtask

  task automatic test_reset();
    link.mse_sle = 1'b0;
    link.mse_sdi = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (link.mse_srdy !== 1'b1 || link.mse_sdo !== 1'b0 || reg_wr !== 1'b0 || reg_rd !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl srdy=%b sdo=%b wr=%b rd=%b exp 1,0,0,0",
               link.mse_srdy, link.mse_sdo, reg_wr, reg_rd);
    end
    checks++;
    if (reg_addr !== 7'h00 || reg_wdata !== 8'h00 || err_cnt !== 8'h00) begin
      failures++;
      $display("FAIL reset_regs addr=%h wdata=%h err=%h exp 0,0,0", reg_addr, reg_wdata, err_cnt);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (link.mse_srdy !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_srdy got=%b exp=1", link.mse_srdy);
    end
  endtask

  task automatic test_write();
    send_frame(1'b0, 7'h05, 8'hA5, -1, 0);
    checks++;
    if (dut_bank[5] !== 8'hA5) begin
      failures++;
      $display("FAIL write_bank got=%h exp=a5", dut_bank[5]);
    end
  endtask

  task automatic test_read();
    send_frame(1'b0, 7'h12, 8'h3C, -1, 1);
    send_frame(1'b1, 7'h12, 8'h00, -1, 0);
  endtask

  task automatic test_abort();
    send_frame(1'b0, 7'h33, 8'h5A, 12, 0);
    checks++;
    if (dut_bank[7'h33] !== 8'h00) begin
      failures++;
      $display("FAIL abort_no_write got=%h exp=00", dut_bank[7'h33]);
    end
  endtask

  task automatic test_back_to_back();
    send_frame(1'b0, 7'h01, 8'h11, -1, 0);
    send_frame(1'b0, 7'h02, 8'h22, -1, 0);
    checks++;
    if (dut_bank[1] !== 8'h11 || dut_bank[2] !== 8'h22) begin
      failures++;
      $display("FAIL b2b_bank got=%h,%h exp=11,22", dut_bank[1], dut_bank[2]);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit [16:0] fr;
    fr = {1'b0, 7'h44, 1'b0, 8'hC3};
    for (int k = 0; k < 12; k++) begin
      link.mse_sle = 1'b1;
      link.mse_sdi = fr[16-k];
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (link.mse_srdy !== 1'b1 || link.mse_sdo !== 1'b0 || reg_wr !== 1'b0 || reg_rd !== 1'b0) begin
      failures++;
      $display("FAIL midreset_ctrl srdy=%b sdo=%b wr=%b rd=%b exp 1,0,0,0",
               link.mse_srdy, link.mse_sdo, reg_wr, reg_rd);
    end
    checks++;
    if (reg_addr !== 7'h00 || reg_wdata !== 8'h00 || err_cnt !== 8'h00) begin
      failures++;
      $display("FAIL midreset_regs addr=%h wdata=%h err=%h exp 0,0,0", reg_addr, reg_wdata, err_cnt);
    end
    link.mse_sle = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_err = 0;
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (wr_cnt !== exp_wr_cnt || dut_bank[7'h44] !== 8'h00) begin
      failures++;
      $display("FAIL midreset_no_write wr_cnt=%0d exp=%0d bank=%h exp=00",
               wr_cnt, exp_wr_cnt, dut_bank[7'h44]);
    end
    checks++;
    if (err_cnt !== 8'h00 || link.mse_srdy !== 1'b1) begin
      failures++;
      $display("FAIL midreset_after err=%0d srdy=%b exp 0,1", err_cnt, link.mse_srdy);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      bit       rw;
      bit [6:0] a;
      bit [7:0] d;
      int       ab;
      rw = 1'($urandom_range(0, 1));
      a  = 7'($urandom_range(0, 15));
      d  = 8'($urandom);
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 16)) : -1;
      send_frame(rw, a, d, ab, int'($urandom_range(0, 2)));
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (dut_bank[i] !== ref_bank[i]) begin
        failures++;
        $display("FAIL random_bank addr=%0d got=%h exp=%h", i, dut_bank[i], ref_bank[i]);
      end
    end
  endtask

  task automatic test_err_saturation();
    for (int n = 0; n < 260; n++) begin
      send_frame(1'b0, 7'h7F, 8'hFF, int'($urandom_range(1, 16)), 0);
    end
    checks++;
    if (err_cnt !== 8'd255) begin
      failures++;
      $display("FAIL err_saturation got=%0d exp=255", err_cnt);
    end
    send_frame(1'b0, 7'h7E, 8'h81, -1, 0);
  endtask

  initial begin
    link.mse_sle = 1'b0;
    link.mse_sdi = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_abort();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    test_err_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mse_serial_slave.md
# mse_serial_slave

Serial front end for the MSE link. It decodes framed serial transactions on MSE_SDI/MSE_SLE into single-cycle register read and write strobes for the port I/O register bank. It returns read data on MSE_SDO and reports readiness on MSE_SRDY. It sits directly upstream of the port I/O block and is clocked by the link clock.

## Interface
- ADDR_W, 7: register address width.
- DATA_W, 8: register data width.
- MSE_SCLK  in  1  link clock; the only clock in the block.
- MSE_RESETN  in  1  reset, asynchronous, active-low.
- mse_sdi  in  1  serial data in, sampled on the rising MSE_SCLK edge.
- mse_sle  in  1  frame enable; high means a frame is active.
- mse_sdo  out  1  serial read data out, registered.
- mse_srdy  out  1  high when the block is idle and will accept a new frame.
- reg_addr  out  ADDR_W  register address; held from address complete until the next frame starts.
- reg_wdata  out  DATA_W  write data; valid while reg_wr is high.
- reg_wr  out  1  one-cycle write strobe.
- reg_rd  out  1  one-cycle read strobe.
- reg_rdata  in  DATA_W  read data; must be valid combinationally in the cycle reg_rd is high.
- err_cnt  out  8  count of aborted frames; saturates at 255.

## Operation
- Frame length is FRAME_LEN = 2 + ADDR_W + DATA_W, which is 17 with the defaults. Bits are indexed 0..16 in MSB-first order.
  - Bit 0: R/W flag, 1 = read.
  - Bits 1..7: address.
  - Bit 8: turnaround, ignored.
  - Bits 9..16: data. The host drives data bits for a write; the block returns them for a read.
- FSM states and transitions:
  - IDLE: mse_srdy = 1. A rising-edge sample with mse_sle = 1 captures bit 0 and moves to ADDR.
  - ADDR: shifts in address bits 1..7. After bit 7, reg_addr is updated and the FSM moves to TURN.
  - TURN: for a read, reg_rd = 1 in this cycle and reg_rdata is captured at the end of it. The FSM moves to DATA.
  - DATA: for a write, shifts mse_sdi into the data register. For a read, shifts the captured word out on mse_sdo. After bit 16 the FSM moves to DONE.
  - DONE: for a write, reg_wr = 1 for exactly one cycle, with reg_wdata equal to the received byte. The FSM then waits for mse_sle = 0 and returns to IDLE. Bits sampled while waiting are ignored.
- Abort: if mse_sle is sampled 0 in ADDR, TURN or DATA, the FSM goes to IDLE and err_cnt increments, saturating at 255. An aborted write never raises reg_wr. An aborted read has already issued its reg_rd and is not retried.
- mse_sle = 0 sampled in DONE is a normal end of frame and does not count as an error. The write strobe still fires.
- mse_sdo is 0 outside the DATA phase of a read.
- mse_srdy is 0 in every state except IDLE.
- A frame may start on the cycle immediately after mse_srdy returns high. Back-to-back frames with a single low cycle of mse_sle are legal.
- Reset (async assert, sync deassert handled at the top level):
  - State IDLE.
  - mse_srdy = 1.
  - mse_sdo, reg_wr and reg_rd = 0.
  - reg_addr, reg_wdata and err_cnt = 0.
  - A reset in mid-frame discards the frame with no strobe and no error count.

## Timing
- Edge k is the rising edge that samples frame bit k.
- reg_addr is valid after edge 7.
- reg_rd is high between edge 7 and edge 8; reg_rdata is sampled at edge 8.
- mse_sdo presents read data bit 7 (MSB) after edge 8 and bit 0 after edge 15. Each bit is stable across the host sampling edge 9..16.
- reg_wr is high between edge 16 and edge 17. Latency from the last data bit sampled to the write strobe is 1 cycle.
- mse_srdy returns to 1 one cycle after mse_sle is sampled low in DONE, or one cycle after an abort.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Package mse_pkg holds:
  - FRAME_LEN and the bit-index constants ADDR_LAST = 7, TURN_BIT = 8, DATA_LAST = 16.
  - The FSM state enum (IDLE, ADDR, TURN, DATA, DONE).
  - The R/W encoding constants.
- One sub-module, mse_shift_reg: a DATA_W-wide shifter with load (from reg_rdata), shift-in (from mse_sdi) and MSB-out. It is instantiated once and shared by the address, write-data and read-data paths.
- The bit counter and FSM stay in the top of the block.

## Test plan
- Write frame R/W=0, addr 0x05, data 0xA5 -> reg_wr high for exactly 1 cycle after edge 16, reg_addr = 0x05, reg_wdata = 0xA5; err_cnt stays 0.
- Read frame addr 0x12 with reg_rdata = 0x3C in the reg_rd cycle -> reg_rd pulses once between edges 7 and 8; mse_sdo carries 0,0,1,1,1,1,0,0 at edges 9..16.
- mse_sle dropped after bit 11 of a write -> no reg_wr, err_cnt = 1, mse_srdy = 1 on the next cycle.
- Two back-to-back writes (0x01←0x11, 0x02←0x22) separated by one low mse_sle cycle -> two reg_wr pulses with the correct address/data pairs, no errors.
- MSE_RESETN asserted in DATA of a write -> all outputs at reset values immediately; no reg_wr after release; err_cnt = 0.
- 260 aborted frames -> err_cnt saturates at 255.
